// File: rtl/fir_pkg.sv
// Shared fixed-point definitions for the FIR output path: default word
// lengths, the sample type, accumulator sizing and the requantizer.
package fir_pkg;

   localparam int DEF_IN_INTE_WL  = 4;
   localparam int DEF_IN_FRAC_WL  = 8;
   localparam int DEF_OUT_INTE_WL = 4;
   localparam int DEF_OUT_FRAC_WL = 8;

   typedef logic signed [DEF_IN_INTE_WL+DEF_IN_FRAC_WL-1:0] sample_t;

   function automatic int acc_w(input int in_w, input int decim);
      return in_w + $clog2(decim);
   endfunction

   // Result is in output LSB units, clamped to the output range; the wide
   // intermediate keeps the rounding add from ever wrapping.
   function automatic logic signed [63:0] requant(
      input logic signed [63:0] x,
      input int                 in_frac,
      input int                 out_inte,
      input int                 out_frac,
      input bit                 rnd
   );
      logic signed [63:0] y;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      if (out_frac >= in_frac) begin
         y = x <<< (out_frac - in_frac);
      end else begin
         y = x;
         if (rnd) begin
            y = y + (64'sd1 <<< (in_frac - out_frac - 1));
         end
         y = y >>> (in_frac - out_frac);
      end
      hi = (64'sd1 <<< (out_inte + out_frac - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_inte + out_frac - 1));
      if (y > hi) begin
         y = hi;
      end else if (y < lo) begin
         y = lo;
      end
      return y;
   endfunction

endpackage

// File: rtl/fir_decim_out_if.sv
// Fixed-point sample stream with valid/ready; the source drives data/valid.
interface fir_decim_out_if #(
   parameter int INTE_WL = 4,
   parameter int FRAC_WL = 8
);
   logic signed [INTE_WL-1:-FRAC_WL] data;
   logic                             valid;
   logic                             ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/fir_out_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO without a same-cycle
// pop is dropped and latches a sticky overflow flag.
module fir_out_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic             overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] last_q, last_d;
   logic             overflow_q, overflow_d;
   logic             pop_en, wr_en, drop;

   assign empty    = (count_q == '0);
   assign full     = (count_q == FULL_CNT);
   assign pop_en   = pop && !empty && !clr;
   assign wr_en    = push && !clr && (!full || pop_en);
   assign drop     = push && !clr && full && !pop_en;
   assign overflow = overflow_q;
   // When empty the output keeps showing whatever was presented last.
   assign rdata    = empty ? last_q : mem_q[rd_ptr_q];

   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      last_d     = rdata;
      overflow_d = overflow_q | drop;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_en) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (pop_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         count_d = count_q + (AW+1)'(wr_en) - (AW+1)'(pop_en);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         last_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         last_q     <= last_d;
         overflow_q <= overflow_d;
      end
   end

endmodule

// File: rtl/fir_decim_out.sv
// Integrate-and-dump decimator feeding a requantizer and output FIFO.
// Define FIR_DECIM_ROUND_EN for round-half-up instead of floor.
module fir_decim_out
   import fir_pkg::*;
#(
   parameter int IN_INTE_WL  = DEF_IN_INTE_WL,
   parameter int IN_FRAC_WL  = DEF_IN_FRAC_WL,
   parameter int OUT_INTE_WL = DEF_OUT_INTE_WL,
   parameter int OUT_FRAC_WL = DEF_OUT_FRAC_WL,
   parameter int DECIM       = 4,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   fir_decim_out_if.slave  in_if,
   fir_decim_out_if.master out_if,
   output logic            overflow
);
   localparam int IN_W  = IN_INTE_WL + IN_FRAC_WL;
   localparam int OUT_W = OUT_INTE_WL + OUT_FRAC_WL;
   localparam int LOG2D = $clog2(DECIM);
   localparam int ACC_W = acc_w(IN_W, DECIM);
`ifdef FIR_DECIM_ROUND_EN
   localparam bit ROUND_EN = 1'b1;
   localparam logic signed [ACC_W-1:0] DUMP_BIAS = ACC_W'(DECIM / 2);
`else
   localparam bit ROUND_EN = 1'b0;
`endif

   logic signed [IN_W-1:0]  sample;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [ACC_W-1:0] sum, dump_sum;
   logic [LOG2D-1:0]        phase_q, phase_d;
   logic signed [IN_W-1:0]  avg_q, avg_d;
   logic                    avg_valid_q, avg_valid_d;
   logic                    last_phase;
   logic [OUT_W-1:0]        req_word;
   logic [OUT_W-1:0]        fifo_rdata;
   logic                    fifo_empty;
   logic                    full_unused;

   // Input is never back-pressured.
   assign in_if.ready = 1'b1;
   assign sample      = in_if.data;
   assign sum         = acc_q + {{LOG2D{sample[IN_W-1]}}, sample};
   assign last_phase  = (phase_q == LOG2D'(DECIM - 1));
`ifdef FIR_DECIM_ROUND_EN
   assign dump_sum    = sum + DUMP_BIAS;
`else
   assign dump_sum    = sum;
`endif

   always_comb begin
      acc_d       = acc_q;
      phase_d     = phase_q;
      avg_d       = avg_q;
      avg_valid_d = 1'b0;
      if (clr) begin
         acc_d   = '0;
         phase_d = '0;
      end else if (in_if.valid) begin
         if (last_phase) begin
            avg_d       = IN_W'(dump_sum >>> LOG2D);
            acc_d       = '0;
            phase_d     = '0;
            avg_valid_d = 1'b1;
         end else begin
            acc_d   = sum;
            phase_d = phase_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q       <= '0;
         phase_q     <= '0;
         avg_q       <= '0;
         avg_valid_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         phase_q     <= phase_d;
         avg_q       <= avg_d;
         avg_valid_q <= avg_valid_d;
      end
   end

   assign req_word = OUT_W'(requant({{(64-IN_W){avg_q[IN_W-1]}}, avg_q},
                                    IN_FRAC_WL, OUT_INTE_WL, OUT_FRAC_WL, ROUND_EN));

   fir_out_fifo #(
      .WIDTH (OUT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .push     (avg_valid_q),
      .wdata    (req_word),
      .pop      (out_if.ready),
      .rdata    (fifo_rdata),
      .full     (full_unused),
      .empty    (fifo_empty),
      .overflow (overflow)
   );

   assign out_if.valid = !fifo_empty;
   assign out_if.data  = fifo_rdata;

endmodule

// File: tb/tb_fir_decim_out.sv
// Directed bench for fir_decim_out: decimation table, latency, saturation,
// FIFO overflow, clear with idle gaps, and mid-block reset.
module tb_fir_decim_out;
   import fir_pkg::*;

   typedef struct {
      sample_t    s [4];
      logic [11:0] exp_main;
      logic [9:0]  exp_sat;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic clr = 1'b0;
   logic overflow, overflow_sat;
   logic [11:0] dout;
   logic [9:0]  dout_s;
   logic        capture_en = 1'b0;
   logic [11:0] cap_q [$];
   logic [11:0] gold [3];
   vec_t        vecs [7];
   int          n_checks = 0;
   int          n_fail = 0;

   fir_decim_out_if #(.INTE_WL(4), .FRAC_WL(8)) in_if ();
   fir_decim_out_if #(.INTE_WL(4), .FRAC_WL(8)) out_if ();
   fir_decim_out_if #(.INTE_WL(4), .FRAC_WL(8)) in_sat_if ();
   fir_decim_out_if #(.INTE_WL(2), .FRAC_WL(8)) out_sat_if ();

   fir_decim_out dut (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .in_if    (in_if),
      .out_if   (out_if),
      .overflow (overflow)
   );

   fir_decim_out #(.OUT_INTE_WL(2)) dut_sat (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .in_if    (in_sat_if),
      .out_if   (out_sat_if),
      .overflow (overflow_sat)
   );

   always #5 clk = ~clk;

   assign dout   = out_if.data;
   assign dout_s = out_sat_if.data;

   always @(negedge clk) begin
      if (capture_en && out_if.valid && out_if.ready) cap_q.push_back(dout);
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input sample_t s, input logic v);
      in_if.data      = s;
      in_if.valid     = v;
      in_sat_if.data  = s;
      in_sat_if.valid = v;
      @(posedge clk);
      #1;
   endtask

   task automatic setReady(input logic r);
      out_if.ready     = r;
      out_sat_if.ready = r;
   endtask

   task automatic setVec(input int idx, input sample_t a, input sample_t b, input sample_t c,
                         input sample_t d, input logic [11:0] em, input logic [9:0] es);
      vecs[idx].s[0]     = a;
      vecs[idx].s[1]     = b;
      vecs[idx].s[2]     = c;
      vecs[idx].s[3]     = d;
      vecs[idx].exp_main = em;
      vecs[idx].exp_sat  = es;
   endtask

   task automatic feedWithGap(input sample_t s);
      applyStimulus(s, 1'b1);
      repeat ($urandom_range(0, 3)) applyStimulus('0, 1'b0);
   endtask

   // Reference block average: floor division of the sum, optional half-up bias.
   function automatic logic [11:0] modelAvg(input sample_t a, input sample_t b,
                                            input sample_t c, input sample_t d);
      int s;
      int q;
      s = int'(a) + int'(b) + int'(c) + int'(d);
`ifdef FIR_DECIM_ROUND_EN
      s = s + 2;
`endif
      q = (s >= 0) ? s / 4 : -((-s + 3) / 4);
      return 12'(q);
   endfunction

   initial begin
`ifdef FIR_DECIM_ROUND_EN
      setVec(1, 12'h001, 12'h002, 12'h003, 12'h004, 12'h003, 10'h003);
      setVec(2, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFE, 12'hFFF, 10'h3FF);
      setVec(6, 12'h006, 12'h006, 12'h007, 12'h007, 12'h007, 10'h007);
`else
      setVec(1, 12'h001, 12'h002, 12'h003, 12'h004, 12'h002, 10'h002);
      setVec(2, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFE, 12'hFFE, 10'h3FE);
      setVec(6, 12'h006, 12'h006, 12'h007, 12'h007, 12'h006, 10'h006);
`endif
      setVec(0, 12'h100, 12'h100, 12'h100, 12'h100, 12'h100, 10'h100);
      setVec(3, 12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF, 10'h1FF);
      setVec(4, 12'h800, 12'h800, 12'h800, 12'h800, 12'h800, 10'h200);
      setVec(5, 12'h010, 12'h020, 12'h030, 12'h040, 12'h028, 10'h028);

      in_if.data = '0;  in_if.valid = 1'b0;
      in_sat_if.data = '0;  in_sat_if.valid = 1'b0;
      setReady(1'b1);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_valid", out_if.valid, 0);
      checkOutput("reset_data", dout, 0);
      checkOutput("reset_overflow", overflow, 0);
      checkOutput("in_ready", in_if.ready, 1);
      rst = 1'b1;
      applyStimulus('0, 1'b0);

      for (int v = 0; v < 7; v++) begin
         for (int i = 0; i < 4; i++) applyStimulus(vecs[v].s[i], 1'b1);
         checkOutput($sformatf("vec%0d_early", v), out_if.valid, 0);
         applyStimulus('0, 1'b0);
         checkOutput($sformatf("vec%0d_valid", v), out_if.valid, 1);
         checkOutput($sformatf("vec%0d_data", v), dout, vecs[v].exp_main);
         checkOutput($sformatf("vec%0d_sat", v), dout_s, vecs[v].exp_sat);
         applyStimulus('0, 1'b0);
         checkOutput($sformatf("vec%0d_pop", v), out_if.valid, 0);
         checkOutput($sformatf("vec%0d_hold", v), dout, vecs[v].exp_main);
      end

      // Eight back-to-back samples: out_valid pulses two edges after samples 4 and 8.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(12'h100, 1'b1);
         checkOutput($sformatf("contig_valid_%0d", i), out_if.valid, (i == 4));
         if (i == 4) checkOutput("contig_data_a", dout, 12'h100);
      end
      applyStimulus('0, 1'b0);
      checkOutput("contig_valid_b", out_if.valid, 1);
      checkOutput("contig_data_b", dout, 12'h100);
      applyStimulus('0, 1'b0);
      checkOutput("contig_drain", out_if.valid, 0);

      checkOutput("ovf_before", overflow, 0);
      setReady(1'b0);
      for (int b = 0; b < 5; b++) begin
         for (int i = 0; i < 4; i++) applyStimulus(sample_t'(16 * (b + 1)), 1'b1);
      end
      applyStimulus('0, 1'b0);
      applyStimulus('0, 1'b0);
      checkOutput("ovf_flag", overflow, 1);
      checkOutput("ovf_flag_sat", overflow_sat, 1);
      checkOutput("ovf_head", dout, 12'h010);
      setReady(1'b1);
      for (int j = 0; j < 4; j++) begin
         checkOutput($sformatf("ovf_pop%0d_valid", j), out_if.valid, 1);
         checkOutput($sformatf("ovf_pop%0d_data", j), dout, 32'(16 * (j + 1)));
         applyStimulus('0, 1'b0);
      end
      checkOutput("ovf_empty", out_if.valid, 0);
      repeat (3) applyStimulus('0, 1'b0);
      checkOutput("ovf_no_fifth", out_if.valid, 0);
      checkOutput("ovf_hold_last", dout, 12'h040);

      // Clear mid-block with a same-cycle sample; overflow must survive it.
      gold[0] = modelAvg(12'h030, 12'h050, 12'h070, 12'h010);
      gold[1] = modelAvg(12'h011, 12'h022, 12'h033, 12'h044);
      gold[2] = modelAvg(12'hFF0, 12'hFF0, 12'hFF0, 12'hFEF);
      cap_q.delete();
      capture_en = 1'b1;
      feedWithGap(12'h030); feedWithGap(12'h050); feedWithGap(12'h070); feedWithGap(12'h010);
      feedWithGap(12'h7FF); feedWithGap(12'h7FF); feedWithGap(12'h7FF);
      clr = 1'b1;
      applyStimulus(12'h7FF, 1'b1);
      clr = 1'b0;
      feedWithGap(12'h011); feedWithGap(12'h022); feedWithGap(12'h033); feedWithGap(12'h044);
      feedWithGap(12'hFF0); feedWithGap(12'hFF0); feedWithGap(12'hFF0); feedWithGap(12'hFEF);
      repeat (8) applyStimulus('0, 1'b0);
      capture_en = 1'b0;
      checkOutput("clr_count", cap_q.size(), 3);
      for (int k = 0; k < 3; k++) begin
         checkOutput($sformatf("clr_out%0d", k), (k < cap_q.size()) ? cap_q[k] : 12'hxxx, gold[k]);
      end
      checkOutput("clr_keeps_overflow", overflow, 1);

      // Reset two samples into a block; the stale partial sum must vanish.
      applyStimulus(12'h100, 1'b1);
      applyStimulus(12'h100, 1'b1);
      in_if.valid = 1'b0;
      in_sat_if.valid = 1'b0;
      rst = 1'b0;
      #1;
      checkOutput("rst_valid", out_if.valid, 0);
      checkOutput("rst_data", dout, 0);
      checkOutput("rst_overflow", overflow, 0);
      checkOutput("rst_data_sat", dout_s, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus(12'h040, 1'b1);
      applyStimulus('0, 1'b0);
      applyStimulus('0, 1'b0);
      checkOutput("rst_no_stale", out_if.valid, 0);
      applyStimulus(12'h040, 1'b1);
      applyStimulus('0, 1'b0);
      checkOutput("rst_first_valid", out_if.valid, 1);
      checkOutput("rst_first_data", dout, 12'h040);
      applyStimulus('0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fir_decim_out.md
Name: fir_decim_out

Overview:
- Stage directly downstream of FIR. Consumes FIR's fixed-point output stream (data_out/out_valid).
- Performs integrate-and-dump decimation by DECIM, then requantizes to the output word format.
- Buffers results in a small FIFO with a valid/ready handshake toward the sink. FIR has no backpressure, so overrun is detected and flagged instead of stalling upstream.

Parameters:
- IN_INTE_WL, 4, integer bits of input (sign included), matches FIR OUT_INTE_WL
- IN_FRAC_WL, 8, fractional bits of input, matches FIR OUT_FRAC_WL
- OUT_INTE_WL, 4, integer bits of output (sign included)
- OUT_FRAC_WL, 8, fractional bits of output
- DECIM, 4, decimation factor; power of 2, range 2..64
- FIFO_DEPTH, 4, output FIFO entries; power of 2, minimum 2

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous assert, active-low
- data_in  in  IN_INTE_WL+IN_FRAC_WL  signed two's-complement sample, indexed [IN_INTE_WL-1:-IN_FRAC_WL]
- in_valid  in  1  data_in valid this cycle; always accepted
- clr  in  1  synchronous clear of partial block and FIFO
- data_out  out  OUT_INTE_WL+OUT_FRAC_WL  decimated sample, indexed [OUT_INTE_WL-1:-OUT_FRAC_WL]
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  sink accepts data_out this cycle
- overflow  out  1  sticky: a result was dropped because the FIFO was full

Behaviour:
- Reset (rst=0): accumulator, phase counter, avg register, avg_valid, FIFO pointers and count are all 0. Outputs: data_out=0, out_valid=0, overflow=0. Reset mid-block discards the partial block.
- Accumulator width: IN_W + log2(DECIM). Each sample is sign-extended before addition, so the accumulator cannot overflow.
- Phase counter runs 0..DECIM-1 and advances only on in_valid. Gaps in in_valid do not affect results.
- Dump: on in_valid with phase==DECIM-1:
  - avg <= (acc + sample) >>> log2(DECIM) (arithmetic shift; floor by default).
  - acc <= 0, phase <= 0, avg_valid <= 1 for one cycle.
- Requantize avg (combinational, before the FIFO write):
  - Fractional bits: if OUT_FRAC_WL >= IN_FRAC_WL, zero-pad. Otherwise drop LSBs with floor by default.
  - Integer bits: if OUT_INTE_WL < IN_INTE_WL, saturate to the max/min representable value. Otherwise sign-extend.
- FIFO write on avg_valid.
- Latency: the Nth in_valid sample accepted at edge k gives avg_valid after edge k and out_valid high after edge k+1 (2 cycles).
- FIFO is show-ahead: data_out = entry at read pointer whenever out_valid=1. data_out holds its last value when empty (0 after reset).
- Pop on out_valid && out_ready.
- Write while full:
  - With a pop in the same cycle: write is accepted (count unchanged).
  - Without a pop: result dropped, overflow <= 1 (sticky until rst).
- Read/write pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
- clr=1 on an edge:
  - acc, phase, avg_valid and FIFO are emptied; overflow is kept.
  - A sample with in_valid in the same cycle is discarded; clr has priority.
- out_ready while empty: ignored.

Optional Feature:
- Macro: FIR_DECIM_ROUND_EN.
- Defined: round-half-up at both truncation points.
  - Dump: add 2^(log2(DECIM)-1) to the sum before the shift.
  - Requantize: add 1 at the MSB of the dropped fractional bits. The rounding add saturates at positive full scale and never wraps.
- Undefined: pure floor (truncation) at both points, with no rounding adders.

Decomposition:
- Package fir_pkg:
  - Localparams for default word lengths.
  - Function clog2-based ACC_W(IN_W, DECIM).
  - Function requant(sat/round) shared with FIR.
  - Typedef for the signed sample type.
- Sub-module fir_out_fifo: parameterized show-ahead synchronous FIFO with push, pop, full, empty and the drop/overflow output.

Test Plan:
- Constant 0x100 (1.0), 8 contiguous samples, out_ready=1 -> two outputs 0x100. out_valid rises 2 cycles after the 4th and 8th samples.
- Raw samples 1,2,3,4 -> 0x002 (floor). With FIR_DECIM_ROUND_EN -> 0x003. Raw -1,-1,-1,-2 -> 0xFFE (floor); with round -> 0xFFF.
- OUT_INTE_WL=2, four samples 0x7FF -> data_out saturates to 0x1FF. Four samples 0x800 -> 0x200.
- out_ready=0, 5 blocks (20 samples) of distinct constants 0x010..0x050 -> overflow=1, FIFO holds 0x010..0x040. Then out_ready=1 -> exactly 4 pops in order; 0x050 never appears.
- rst pulled low after 2 samples of a block -> all outputs 0 immediately. After release, the 2 stale samples do not contribute; the first output appears only after 4 new samples.
- Samples separated by random 0–3 idle cycles; clr pulsed after the 3rd sample of one block -> results equal a contiguous-input golden model that restarts the block at clr; overflow is unaffected.
